// File: rtl/lock_pkg.sv
// Shared state encoding and key-code decode helpers for the keypad lock controller.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ENTRY       = 3'd1,
        OPEN        = 3'd2,
        SET_NEW     = 3'd3,
        SET_CONFIRM = 3'd4,
        LOCKOUT     = 3'd5
    } lock_state_t;

    // The top three key codes are reserved: cancel, set, and an ignored code.
    function automatic int unsigned key_cancel(input int unsigned dw);
        return (32'd1 << dw) - 32'd3;
    endfunction

    function automatic int unsigned key_set(input int unsigned dw);
        return (32'd1 << dw) - 32'd2;
    endfunction

    function automatic logic is_digit(input int unsigned code, input int unsigned dw);
        return code < key_cancel(dw);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done marks the final cycle of the loaded interval.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // A load of N keeps the owning state alive for exactly N cycles.
    assign done = (cnt <= W'(1));

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock: passcode entry, timed unlock, failure lockout and passcode change.
module keypad_lock_ctrl
    import lock_pkg::*;
#(
    parameter int                            CODE_LEN       = 4,
    parameter int                            DIGIT_W        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   RESET_CODE     = 16'h1234,
    parameter int                            UNLOCK_CYCLES  = 5,
    parameter int                            MAX_TRIES      = 3,
    parameter int                            LOCKOUT_CYCLES = 100
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               key_valid,
    input  logic [DIGIT_W-1:0]                 key_code,
    output logic                               unlocked,
    output logic                               locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt,
    output logic                               ok_pulse,
    output logic                               err_pulse,
    output logic [2:0]                         state_o
);

    localparam int CW      = CODE_LEN * DIGIT_W;
    localparam int IW      = $clog2(CODE_LEN + 1);
    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);

    lock_state_t   state;
    logic [IW-1:0] idx, idx_base;
    logic [CW-1:0] code, ent_buf, new_buf, ent_full, new_full;
    logic          is_dig, is_cancel, is_set, last_digit;
    logic          ent_match, cfm_match, will_lock;
    logic          tmr_load, tmr_done;
    logic [TW-1:0] tmr_val;

    // Buffers shift digits in from the LSB end so digit 0 lands in the MSBs.
    always_comb begin
        is_dig     = key_valid && is_digit(32'(key_code), DIGIT_W);
        is_cancel  = key_valid && (32'(key_code) == key_cancel(DIGIT_W));
        is_set     = key_valid && (32'(key_code) == key_set(DIGIT_W));
        idx_base   = (state == IDLE) ? '0 : idx;
        last_digit = (32'(idx_base) == 32'(CODE_LEN - 1));
        ent_full   = CW'({ent_buf, key_code});
        new_full   = CW'({new_buf, key_code});
        ent_match  = (ent_full == code);
        cfm_match  = (ent_full == new_buf);
        will_lock  = (32'(fail_cnt) + 32'd1 >= 32'(MAX_TRIES));
        tmr_load   = is_dig && last_digit && (state == IDLE || state == ENTRY);
        tmr_val    = ent_match ? TW'(UNLOCK_CYCLES) : TW'(LOCKOUT_CYCLES);
    end

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (is_cancel && state != LOCKOUT) begin
            ent_buf <= '0;
            new_buf <= '0;
        end else if (is_dig) begin
            if (state == IDLE || state == ENTRY || state == SET_CONFIRM)
                ent_buf <= ent_full;
            if (state == SET_NEW)
                new_buf <= new_full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            fail_cnt   <= '0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
            ok_pulse   <= 1'b0;
            err_pulse  <= 1'b0;
            code       <= RESET_CODE;
        end else begin
            ok_pulse  <= 1'b0;
            err_pulse <= 1'b0;
            case (state)
                IDLE, ENTRY: begin
                    if (is_cancel) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else if (is_dig) begin
                        if (last_digit) begin
                            idx <= '0;
                            if (ent_match) begin
                                state    <= OPEN;
                                unlocked <= 1'b1;
                                ok_pulse <= 1'b1;
                                fail_cnt <= '0;
                            end else begin
                                err_pulse <= 1'b1;
                                fail_cnt  <= fail_cnt + 1'b1;
                                if (will_lock) begin
                                    state      <= LOCKOUT;
                                    locked_out <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end else begin
                            state <= ENTRY;
                            idx   <= idx_base + 1'b1;
                        end
                    end
                end
                OPEN: begin
                    // A key arriving on the expiry cycle takes priority over the timeout.
                    if (is_set) begin
                        state    <= SET_NEW;
                        idx      <= '0;
                        unlocked <= 1'b0;
                    end else if (is_cancel || tmr_done) begin
                        state    <= IDLE;
                        idx      <= '0;
                        unlocked <= 1'b0;
                    end
                end
                SET_NEW, SET_CONFIRM: begin
                    if (is_cancel) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else if (is_dig) begin
                        if (last_digit) begin
                            idx <= '0;
                            if (state == SET_NEW) begin
                                state <= SET_CONFIRM;
                            end else begin
                                state <= IDLE;
                                if (cfm_match) begin
                                    code     <= new_buf;
                                    ok_pulse <= 1'b1;
                                end else begin
                                    err_pulse <= 1'b1;
                                end
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                LOCKOUT: begin
                    if (tmr_done) begin
                        state      <= IDLE;
                        locked_out <= 1'b0;
                        fail_cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: doc/keypad_lock_ctrl.md
# keypad_lock_ctrl

Parametrised keypad lock controller, the next generation of the team's 4-digit electronic lock. It accepts strobed key codes and checks a CODE_LEN-digit passcode, comparing all digits only after the last one is entered. It drives a timed unlock output, counts failed attempts into a timed lockout, and supports passcode change with a confirmation re-entry. It sits between the keypad scanner/debouncer (key strobes) and the actuator driver (unlocked level).

## Interface
- CODE_LEN, 4: digits per passcode (≥1).
- DIGIT_W, 4: key code width (≥3).
- RESET_CODE, 16'h1234: passcode after reset, CODE_LEN*DIGIT_W bits, digit 0 in the MSBs.
- UNLOCK_CYCLES, 5: cycles `unlocked` stays high (≥1).
- MAX_TRIES, 3: consecutive failures that trigger lockout (≥1).
- LOCKOUT_CYCLES, 100: lockout duration in cycles (≥1).
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
- key_code  in  DIGIT_W  key value; the special codes are defined under Operation.
- unlocked  out  1  lock released; reset 0.
- locked_out  out  1  lockout active; reset 0.
- fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failures; reset 0.
- ok_pulse  out  1  one-cycle pulse on a correct code or a committed passcode change; reset 0.
- err_pulse  out  1  one-cycle pulse on a wrong code or a confirmation mismatch; reset 0.
- state_o  out  3  current FSM state for debug; reset IDLE.

## Operation
- Key codes: KEY_CANCEL = 2^DIGIT_W−3; KEY_SET = 2^DIGIT_W−2; 2^DIGIT_W−1 is ignored; any value below KEY_CANCEL is a digit.
- IDLE: a digit stores into buf[0], sets idx=1, and moves to ENTRY. KEY_SET in IDLE is ignored.
- ENTRY: each digit goes into buf[idx] and idx increments. The digit that makes idx reach CODE_LEN triggers the compare of the whole buffer against the stored code.
  - Match: go to OPEN, pulse ok_pulse, clear fail_cnt, load the timer with UNLOCK_CYCLES.
  - Mismatch: pulse err_pulse, increment fail_cnt, return to IDLE. If fail_cnt reaches MAX_TRIES, go to LOCKOUT instead and load the timer with LOCKOUT_CYCLES.
- OPEN: unlocked=1 while the timer counts down; at timer 0, go to IDLE. KEY_SET goes to SET_NEW and drops unlocked. Digits are ignored.
- SET_NEW: collect CODE_LEN digits into the new-code buffer, then go to SET_CONFIRM.
- SET_CONFIRM: collect CODE_LEN digits and compare them with the new-code buffer.
  - Equal: commit the new code, pulse ok_pulse.
  - Different: keep the old code, pulse err_pulse.
  - Either way, go to IDLE.
- LOCKOUT: locked_out=1 and all keys are ignored, including KEY_CANCEL. At timer 0, clear fail_cnt and go to IDLE.
- KEY_CANCEL in any state except LOCKOUT: go to IDLE, clear idx and buffers. fail_cnt is unchanged and no pulse is issued.
- fail_cnt persists across IDLE and is cleared only by a success, lockout expiry, or rst.

## Timing
- All outputs are registered and change on the edge after the key strobe that caused them.
  - A final correct digit strobed at cycle t gives unlocked=1 at t+1, held for exactly UNLOCK_CYCLES cycles.
  - locked_out is high for exactly LOCKOUT_CYCLES cycles.
- A key and timer expiry in the same OPEN cycle: the key wins, so KEY_SET enters SET_NEW.
- Back-to-back strobes on every cycle are accepted; there is no throughput limit.
- rst asserted mid-operation forces IDLE, the code back to RESET_CODE, and all outputs to 0 immediately, independent of clk.

## Structure
- Package lock_pkg holds:
  - the state enum {IDLE, ENTRY, OPEN, SET_NEW, SET_CONFIRM, LOCKOUT};
  - functions key_cancel(DIGIT_W), key_set(DIGIT_W), is_digit(code, DIGIT_W).
- Sub-module lock_timer: a loadable down-counter with a done flag, width $clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1). One instance is shared by OPEN and LOCKOUT.

## Test plan
- Reset, then keys 1,2,3,4 on consecutive cycles -> ok_pulse at t+1, unlocked high for 5 cycles, then state_o=IDLE.
- Keys 1,2,3,5 three times -> err_pulse ×3, fail_cnt 1,2,3; locked_out high for 100 cycles; digits during lockout ignored; fail_cnt=0 after.
- Unlock, KEY_SET (4'hE), 9,8,7,6, 9,8,7,6 -> ok_pulse; then 1,2,3,4 -> err_pulse; then 9,8,7,6 -> unlocked.
- Unlock, KEY_SET, 9,8,7,6, 9,8,7,5 -> err_pulse; 1,2,3,4 still unlocks.
- 1,2, KEY_CANCEL (4'hD), 1,2,3,4 -> unlocks; fail_cnt unchanged by the cancel.
- rst pulsed mid-entry and mid-lockout -> all outputs 0 asynchronously; code returns to RESET_CODE; repeat with CODE_LEN=6, DIGIT_W=5.
